// File: rtl/yadan_ahb_pkg.sv
// Shared AHB-Lite codes and responder state encoding for the SRAM slave.
package yadan_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: return 1'b1;
            HSIZE_HALF: return !lo[0];
            HSIZE_WORD: return lo == 2'b00;
            default:    return 1'b0;
        endcase
    endfunction

    // Little-endian lane enables for an already-legal access.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: return 4'b0001 << lo;
            HSIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side signal bundle between the decoder/mux and the SRAM responder.
interface ahb_sram_slave_if;
    logic        S_HSEL;
    logic [31:0] S_HADDR;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE;
    logic [2:0]  S_HBURST;
    logic        S_HWRITE;
    logic [31:0] S_HWDATA;
    logic        S_HREADY;
    logic        S_HREADYOUT;
    logic        S_HRESP;
    logic [31:0] S_HRDATA;

    modport slave (
        input  S_HSEL, S_HADDR, S_HTRANS, S_HSIZE, S_HBURST, S_HWRITE, S_HWDATA, S_HREADY,
        output S_HREADYOUT, S_HRESP, S_HRDATA
    );

    modport master (
        output S_HSEL, S_HADDR, S_HTRANS, S_HSIZE, S_HBURST, S_HWRITE, S_HWDATA, S_HREADY,
        input  S_HREADYOUT, S_HRESP, S_HRDATA
    );
endinterface

// File: rtl/ahb_sram_bank.sv
// Single-port word SRAM with per-byte write enables and a read register that
// only updates on a read, so its output survives intervening writes.
module ahb_sram_bank #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          re_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem_q[addr_i];
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: programmable wait states, byte/half/word access,
// two-cycle ERROR for illegal transfers, and read-after-write forwarding.
module ahb_sram_slave
    import yadan_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst,
    ahb_sram_slave_if.slave bus
);

    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [1:0]            lo_q;
    logic [2:0]            size_q;
    logic                  wr_q;

    // A write completing on the same edge a read is issued cannot use the
    // single RAM port; it is parked here and committed on the next free edge.
    logic                  pend_vld_q;
    logic [ADDR_WIDTH-1:0] pend_idx_q;
    logic [3:0]            pend_be_q;
    logic [31:0]           pend_data_q;

    logic [3:0]            fwd_be_q;
    logic [31:0]           fwd_data_q;

    logic                  can_acc, accept, legal, rd_issue, wr_done;
    logic [ADDR_WIDTH-1:0] bus_idx;
    logic [3:0]            wr_be;

    logic                  ram_re;
    logic [3:0]            ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata, ram_rdata;

    logic                  src_vld;
    logic [ADDR_WIDTH-1:0] src_idx;
    logic [3:0]            src_be;
    logic [31:0]           src_data;

    logic                  hreadyout, hresp;
    logic [31:0]           hrdata, merged;
    logic                  unused_ok;

    assign unused_ok = ^{bus.S_HBURST, bus.S_HADDR[31:ADDR_WIDTH+2]};

    assign bus_idx  = bus.S_HADDR[ADDR_WIDTH+1:2];
    assign can_acc  = state_q inside {ST_IDLE, ST_DATA, ST_ERR2};
    assign accept   = can_acc && bus.S_HSEL && bus.S_HREADY && bus.S_HTRANS[1];
    assign legal    = xfer_legal(bus.S_HSIZE, bus.S_HADDR[1:0]);
    assign rd_issue = accept && legal && !bus.S_HWRITE;
    assign wr_done  = (state_q == ST_DATA) && wr_q;
    assign wr_be    = byte_en(size_q, lo_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        unique case (state_q)
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (cnt_q == 4'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: begin
                if (state_q == ST_ERR2) hresp = HRESP_ERROR;
                state_d = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    // Port arbitration: a new read wins, then a completing write, then the parked write.
    always_comb begin
        ram_re    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = pend_idx_q;
        ram_wdata = pend_data_q;
        if (!rst) begin
            if (rd_issue) begin
                ram_re   = 1'b1;
                ram_addr = bus_idx;
            end else if (wr_done) begin
                ram_we    = wr_be;
                ram_addr  = idx_q;
                ram_wdata = bus.S_HWDATA;
            end else if (pend_vld_q) begin
                ram_we = pend_be_q;
            end
        end
    end

    always_comb begin
        src_vld  = wr_done || pend_vld_q;
        src_idx  = wr_done ? idx_q        : pend_idx_q;
        src_be   = wr_done ? wr_be        : pend_be_q;
        src_data = wr_done ? bus.S_HWDATA : pend_data_q;
    end

    ahb_sram_bank #(.AW(ADDR_WIDTH)) u_bank (
        .clk     (clk),
        .re_i    (ram_re),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            lo_q        <= 2'b00;
            size_q      <= 3'd0;
            wr_q        <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            pend_be_q   <= 4'b0000;
            pend_data_q <= 32'd0;
            fwd_be_q    <= 4'b0000;
            fwd_data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q  <= bus_idx;
                lo_q   <= bus.S_HADDR[1:0];
                size_q <= bus.S_HSIZE;
                wr_q   <= bus.S_HWRITE;
            end
            if (rd_issue) begin
                fwd_be_q   <= (src_vld && src_idx == bus_idx) ? src_be : 4'b0000;
                fwd_data_q <= src_data;
                if (wr_done) begin
                    pend_vld_q  <= 1'b1;
                    pend_idx_q  <= idx_q;
                    pend_be_q   <= wr_be;
                    pend_data_q <= bus.S_HWDATA;
                end
            end else begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = fwd_be_q[b] ? fwd_data_q[8*b +: 8] : ram_rdata[8*b +: 8];
        end
        hrdata = ((state_q == ST_DATA) && !wr_q) ? merged : 32'd0;
    end

    assign bus.S_HREADYOUT = hreadyout;
    assign bus.S_HRESP     = hresp;
    assign bus.S_HRDATA    = hrdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Two responders (0 and 1 wait states) driven by one pipelined AHB master and
// checked against a byte-level memory model plus per-transfer response timing.
module tb_ahb_sram_slave;

    typedef struct {
        logic        hsel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_g, rst_m, sel;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;

    int          n_chk = 0;
    int          n_err = 0;

    logic [31:0] mdl [2][64];
    xfer_t       q[$];
    xfer_t       dp, nxt;
    bit          dp_v;
    int          dp_cyc;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    ahb_sram_slave_if bus0();
    ahb_sram_slave_if bus1();

    wire rst0 = rst_g | (rst_m & ~sel);
    wire rst1 = rst_g | (rst_m & sel);

    assign bus0.S_HSEL = hsel & ~sel;
    assign bus1.S_HSEL = hsel & sel;
    assign bus0.S_HADDR = haddr;   assign bus1.S_HADDR = haddr;
    assign bus0.S_HTRANS = htrans; assign bus1.S_HTRANS = htrans;
    assign bus0.S_HSIZE = hsize;   assign bus1.S_HSIZE = hsize;
    assign bus0.S_HBURST = hburst; assign bus1.S_HBURST = hburst;
    assign bus0.S_HWRITE = hwrite; assign bus1.S_HWRITE = hwrite;
    assign bus0.S_HWDATA = hwdata; assign bus1.S_HWDATA = hwdata;
    assign bus0.S_HREADY = bus0.S_HREADYOUT;
    assign bus1.S_HREADY = bus1.S_HREADYOUT;

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst0), .bus(bus0));
    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (.clk(clk), .rst(rst1), .bus(bus1));

    wire        obs_rdy  = sel ? bus1.S_HREADYOUT : bus0.S_HREADYOUT;
    wire        obs_resp = sel ? bus1.S_HRESP     : bus0.S_HRESP;
    wire [31:0] obs_rd   = sel ? bus1.S_HRDATA    : bus0.S_HRDATA;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_xfer(input xfer_t x);
        return x.hsel && x.trans[1];
    endfunction

    function automatic bit ok(input xfer_t x);
        return (x.size <= 3'd2) && ((x.addr & ((32'd1 << x.size) - 32'd1)) == 32'd0);
    endfunction

    function automatic xfer_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata);
        xfer_t x;
        x.hsel = 1'b1; x.trans = 2'b10; x.addr = addr; x.size = size;
        x.burst = 3'd0; x.wr = wr; x.wdata = wdata;
        return x;
    endfunction

    function automatic xfer_t idle_x();
        xfer_t x;
        x = mk(1'b0, $urandom(), 3'($urandom_range(0, 3)), $urandom());
        x.hsel = 1'b0; x.trans = 2'b00;
        return x;
    endfunction

    function automatic xfer_t rnd_x();
        xfer_t x;
        int r, t;
        r = $urandom_range(0, 9);
        t = $urandom_range(0, 5);
        x.hsel  = ($urandom_range(0, 9) != 0);
        x.trans = (t == 0) ? 2'b00 : (t == 1) ? 2'b01 : (t < 4) ? 2'b10 : 2'b11;
        x.size  = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
        x.addr  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2);
        if ($urandom_range(0, 9) < 3) x.addr[1:0] = 2'($urandom_range(0, 3));
        x.burst = 3'($urandom_range(0, 7));
        x.wr    = 1'($urandom_range(0, 1));
        x.wdata = $urandom();
        return x;
    endfunction

    // Only the bytes the access covers are replaced.
    function automatic void mdl_wr(input int s, input xfer_t x, input logic [31:0] wd);
        int n, lo;
        n  = 1 << x.size;
        lo = int'(x.addr[1:0]);
        for (int b = 0; b < 4; b++) begin
            if (b >= lo && b < lo + n) mdl[s][x.addr[7:2]][8*b +: 8] = wd[8*b +: 8];
        end
    endfunction

    task automatic drive_a(input xfer_t x);
        hsel = x.hsel; htrans = x.trans; haddr = x.addr;
        hsize = x.size; hburst = x.burst; hwrite = x.wr;
    endtask

    task automatic step();
        logic        e_rdy, e_resp;
        logic [31:0] e_rd;
        int          s;
        @(negedge clk);
        s = int'(sel);
        e_rdy = 1'b1; e_resp = 1'b0; e_rd = 32'd0;
        if (dp_v) begin
            if (ok(dp)) begin
                e_rdy = (dp_cyc == s);
                if (e_rdy && !dp.wr) e_rd = mdl[s][dp.addr[7:2]];
            end else begin
                e_rdy  = (dp_cyc == 1);
                e_resp = 1'b1;
            end
        end
        chk("hreadyout", 32'(obs_rdy), 32'(e_rdy));
        chk("hresp", 32'(obs_resp), 32'(e_resp));
        chk("hrdata", obs_rd, e_rd);
        if (dp_v && e_rdy && ok(dp) && !dp.wr) last_rd = obs_rd;
        hwdata = (dp_v && dp.wr) ? dp.wdata : $urandom();
        drive_a(nxt);
        if (e_rdy) begin
            if (dp_v && ok(dp) && dp.wr) mdl_wr(s, dp, dp.wdata);
            dp_v   = is_xfer(nxt);
            dp     = nxt;
            dp_cyc = 0;
            nxt    = (q.size() > 0) ? q.pop_front() : idle_x();
        end else begin
            dp_cyc++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || dp_v || is_xfer(nxt)) && n < 20000) begin
            step();
            n++;
        end
        chk("drain_left", 32'(q.size()) + 32'(dp_v), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t ix;
        logic [31:0] old80;
        sel = 1'b0; rst_m = 1'b0; rst_g = 1'b1;
        dp_v = 1'b0; dp_cyc = 0; last_rd = 32'd0;
        nxt = idle_x();
        drive_a(nxt);
        hwdata = 32'd0;

        @(negedge clk);
        chk("rst_rdy0", 32'(bus0.S_HREADYOUT), 32'd1);
        chk("rst_resp0", 32'(bus0.S_HRESP), 32'd0);
        chk("rst_rd0", bus0.S_HRDATA, 32'd0);
        chk("rst_rdy1", 32'(bus1.S_HREADYOUT), 32'd1);
        chk("rst_resp1", 32'(bus1.S_HRESP), 32'd0);
        chk("rst_rd1", bus1.S_HRDATA, 32'd0);
        @(negedge clk);
        rst_g = 1'b0;

        // Fill the test window of each SRAM with known words; selected IDLE/BUSY get zero-wait OKAY.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            ix = mk(1'b0, 32'h10, 3'd2, 32'd0); ix.trans = 2'b00; q.push_back(ix);
            ix.trans = 2'b01; q.push_back(ix);
            for (int i = 0; i < 64; i++)
                q.push_back(mk(1'b1, ($urandom() & 32'hFFFF_F000) | (32'(i) << 2), 3'd2, $urandom()));
            drain();
        end

        sel = 1'b1;
        q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
        drain();
        chk("word_rd", last_rd, 32'hDEADBEEF);

        q.push_back(mk(1'b1, 32'h12, 3'd0, 32'h0055_0000));
        q.push_back(mk(1'b1, 32'h10, 3'd1, 32'h0000_A1B2));
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
        drain();
        chk("byte_half", last_rd, 32'hDE55A1B2);

        q.push_back(mk(1'b1, 32'h11, 3'd1, 32'hFFFF_FFFF));
        q.push_back(mk(1'b1, 32'h20, 3'd3, 32'hFFFF_FFFF));
        q.push_back(mk(1'b0, 32'h20, 3'd2, 32'd0));
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
        drain();
        chk("err_nowr", last_rd, 32'hDE55A1B2);

        sel = 1'b0;
        q.push_back(mk(1'b1, 32'h40, 3'd2, 32'h11223344));
        q.push_back(mk(1'b0, 32'h40, 3'd2, 32'd0));
        drain();
        chk("fwd_b2b", last_rd, 32'h11223344);

        // Reset lands while the write sits in its wait state.
        sel = 1'b1;
        old80 = mdl[1][32];
        @(negedge clk);
        drive_a(mk(1'b1, 32'h80, 3'd2, 32'hCAFEF00D));
        @(negedge clk);
        chk("midwait_rdy", 32'(obs_rdy), 32'd0);
        drive_a(idle_x());
        hwdata = 32'hCAFEF00D;
        rst_m  = 1'b1;
        @(negedge clk);
        chk("midrst_rdy", 32'(obs_rdy), 32'd1);
        chk("midrst_resp", 32'(obs_resp), 32'd0);
        chk("midrst_rd", obs_rd, 32'd0);
        rst_m = 1'b0;
        q.push_back(mk(1'b0, 32'h80, 3'd2, 32'd0));
        drain();
        chk("rst_abort", last_rd, old80);

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            repeat (300) q.push_back(rnd_x());
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
